text_cursor_writer: RTL
=======================

Name: text_cursor_writer

Overview:
- Consumer end of the character FIFO handshake (in_data / in_data_available in, receiver_ready out).
- Accepts one word per handshake and either writes a character word into text memory at the current cursor position, or executes a cursor control command.
- Owns the cursor (column/row) and computes the linear text-memory address.
- Sits between the character FIFO and the text-memory write port arbiter.

Parameters:
- DATA_WIDTH, 21, width of FIFO words; bit DATA_WIDTH-1 set means control word, clear means character word.
- COLUMNS, 80, characters per row.
- ROWS, 51, rows in the text buffer.
- ADDR_WIDTH, 13, text-memory address width; must satisfy COLUMNS*ROWS <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  word from FIFO; valid only when in_data_available=1.
- in_data_available  in  1  one-cycle pulse, word present.
- receiver_ready  out  1  registered; 1 = a word may be sent.
- mem_write_request  out  1  level; held until mem_write_done.
- mem_address  out  ADDR_WIDTH  cursor_y*COLUMNS + cursor_x, captured at acceptance.
- mem_data  out  DATA_WIDTH-1  character word (in_data without flag bit).
- mem_write_done  in  1  one-cycle pulse from arbiter, write committed.
- cursor_x  out  7  current column, 0..COLUMNS-1.
- cursor_y  out  6  current row, 0..ROWS-1.
- dropped  out  1  sticky; a word arrived while receiver_ready=0.

Behaviour:
- Reset values: state IDLE, receiver_ready=1, mem_write_request=0, mem_address=0, mem_data=0, cursor_x=0, cursor_y=0, dropped=0.
- A reset asserted mid-write abandons the write: the request falls on the next edge and no cursor advance occurs.
- FSM states: IDLE, WRITE, EXEC.
- IDLE, in_data_available=1 at edge N:
  - receiver_ready goes to 0 at that same edge, so it is 0 before the FIFO next samples it (cycle N+2).
  - Character word: latch mem_data and mem_address at edge N; mem_write_request=1 from cycle N+1; go to WRITE.
  - Control word: apply command at edge N; go to EXEC.
- Control commands (in_data[2:0], other bits ignored):
  - 0 = CR: cursor_x=0.
  - 1 = LF: cursor_y+1, wrapping ROWS-1 -> 0.
  - 2 = HOME: cursor_x=0, cursor_y=0.
  - 3..7: no-op.
- EXEC: one cycle; receiver_ready=1 at the next edge; go to IDLE.
- WRITE:
  - Hold mem_write_request, mem_address and mem_data stable until mem_write_done=1.
  - mem_write_done is honoured even in the first cycle of the request.
  - On mem_write_done at edge M: request=0, receiver_ready=1, state IDLE, cursor advances.
- Cursor advance: x+1; if x==COLUMNS-1 then x=0 and y+1; if additionally y==ROWS-1 then y wraps to 0. No scrolling.
- mem_write_done outside WRITE is ignored.
- in_data_available while receiver_ready=0 (WRITE or EXEC, or the acceptance cycle itself is not affected): word discarded, dropped=1 until reset. No state or cursor change.
- Address arithmetic: y*COLUMNS is unsigned, truncated to ADDR_WIDTH, computed from the registered cursor. Best-case throughput is one character word per 3 cycles, with done in the first request cycle.

Test Plan:
- Reset then character 0x00041 pulsed at cycle 2 -> receiver_ready=0 at cycle 3; request=1, address=0, data=0x0041 from cycle 3. Done pulsed at cycle 5 -> request=0, cursor_x=1, ready=1 at cycle 6.
- Cursor at (79,50), character written, done -> cursor (0,0). Next character gets address 0. Cursor at (79,3) -> (0,4), address of next write 320.
- Control words CR (0x100000), LF (0x100001), HOME (0x100002) from cursor (10,50) -> (0,50), then (0,0) via LF wrap, then (0,0). Each completes with ready=0 for exactly one cycle. Command 0x100005 leaves the cursor unchanged.
- Done asserted in the same cycle the request first rises -> request high exactly one cycle, cursor advances once. Done pulsed while IDLE -> no change.
- Word pulsed during WRITE -> dropped=1, memory data/address unchanged, cursor advances only once. dropped stays 1 until reset.
- Reset asserted while in WRITE with request=1 -> next cycle request=0, cursor (0,0), ready=1. A later mem_write_done pulse is ignored.
- Back-to-back words from a real FIFO instance, arbiter answering in 0..3 cycles -> 200 characters written to consecutive addresses 0..199, no drops.

Source files
------------

// File: rtl/text_cursor_writer_if.sv
// Character FIFO handshake plus text-memory write port, as seen by the cursor writer.
// The slave modport is the writer; the master modport is the FIFO/arbiter side.
interface text_cursor_writer_if #(
    parameter int DATA_WIDTH = 21,
    parameter int ADDR_WIDTH = 13
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_data_available;
    logic                  receiver_ready;
    logic                  mem_write_request;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-2:0] mem_data;
    logic                  mem_write_done;

    modport master (
        output in_data,
        output in_data_available,
        output mem_write_done,
        input  receiver_ready,
        input  mem_write_request,
        input  mem_address,
        input  mem_data
    );

    modport slave (
        input  in_data,
        input  in_data_available,
        input  mem_write_done,
        output receiver_ready,
        output mem_write_request,
        output mem_address,
        output mem_data
    );
endinterface

// File: rtl/text_cursor_writer.sv
// Consumes character/control words from the FIFO, writes characters at the cursor
// into text memory through the arbiter, and executes CR/LF/HOME cursor commands.
module text_cursor_writer #(
    parameter int DATA_WIDTH = 21,
    parameter int COLUMNS    = 80,
    parameter int ROWS       = 51,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    text_cursor_writer_if.slave   bus,
    output logic [6:0]            cursor_x,
    output logic [5:0]            cursor_y,
    output logic                  dropped
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        EXEC
    } state_t;

    localparam logic [2:0] CMD_CR   = 3'd0;
    localparam logic [2:0] CMD_LF   = 3'd1;
    localparam logic [2:0] CMD_HOME = 3'd2;

    state_t                state_reg;
    logic                  receiver_ready_reg;
    logic                  mem_write_request_reg;
    logic [ADDR_WIDTH-1:0] mem_address_reg;
    logic [DATA_WIDTH-2:0] mem_data_reg;
    logic [6:0]            cursor_x_reg;
    logic [5:0]            cursor_y_reg;
    logic                  dropped_reg;

    logic                  x_last;
    logic                  y_last;
    logic [5:0]            y_inc;
    logic [ADDR_WIDTH-1:0] cursor_addr;
    logic                  is_control;
    logic [2:0]            command;

    // Linear address is derived from the registered cursor, truncated to the memory width.
    always_comb begin
        x_last      = (cursor_x_reg == 7'(COLUMNS - 1));
        y_last      = (cursor_y_reg == 6'(ROWS - 1));
        y_inc       = y_last ? 6'd0 : cursor_y_reg + 6'd1;
        cursor_addr = ADDR_WIDTH'(ADDR_WIDTH'(cursor_y_reg) * ADDR_WIDTH'(COLUMNS))
                    + ADDR_WIDTH'(cursor_x_reg);
        is_control  = bus.in_data[DATA_WIDTH-1];
        command     = bus.in_data[2:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg             <= IDLE;
            receiver_ready_reg    <= 1'b1;
            mem_write_request_reg <= 1'b0;
            mem_address_reg       <= '0;
            mem_data_reg          <= '0;
            cursor_x_reg          <= '0;
            cursor_y_reg          <= '0;
            dropped_reg           <= 1'b0;
        end else begin
            // A word offered while we are not ready is lost; remember that until reset.
            if (bus.in_data_available && !receiver_ready_reg) begin
                dropped_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.in_data_available) begin
                        receiver_ready_reg <= 1'b0;
                        if (is_control) begin
                            case (command)
                                CMD_CR: cursor_x_reg <= '0;
                                CMD_LF: cursor_y_reg <= y_inc;
                                CMD_HOME: begin
                                    cursor_x_reg <= '0;
                                    cursor_y_reg <= '0;
                                end
                                default: ;
                            endcase
                            state_reg <= EXEC;
                        end else begin
                            mem_data_reg          <= bus.in_data[DATA_WIDTH-2:0];
                            mem_address_reg       <= cursor_addr;
                            mem_write_request_reg <= 1'b1;
                            state_reg             <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (bus.mem_write_done) begin
                        mem_write_request_reg <= 1'b0;
                        receiver_ready_reg    <= 1'b1;
                        state_reg             <= IDLE;
                        if (x_last) begin
                            cursor_x_reg <= '0;
                            cursor_y_reg <= y_inc;
                        end else begin
                            cursor_x_reg <= cursor_x_reg + 7'd1;
                        end
                    end
                end

                EXEC: begin
                    receiver_ready_reg <= 1'b1;
                    state_reg          <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.receiver_ready    = receiver_ready_reg;
    assign bus.mem_write_request = mem_write_request_reg;
    assign bus.mem_address       = mem_address_reg;
    assign bus.mem_data          = mem_data_reg;
    assign cursor_x              = cursor_x_reg;
    assign cursor_y              = cursor_y_reg;
    assign dropped               = dropped_reg;
endmodule
